// File: rtl/q3_pkg.sv
// Shared types for the window tally block.
//   CNT_W       : width of the per-frame hit count
//   FIFO_DEPTH  : number of result records buffered ahead of the consumer
//   tally_state_t / tally_rec_t : FSM state and result record layout
package q3_pkg;
  localparam int CNT_W      = 4;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic {IDLE, COLLECT} tally_state_t;

  typedef struct packed {
    logic [7:0]       frame_id;
    logic [CNT_W-1:0] hits;
  } tally_rec_t;
endpackage

// File: rtl/q3_result_fifo.sv
// Two-entry first-in first-out buffer of tally records.
//   clk, resetn : clock, asynchronous active-low reset (contents cleared)
//   push, din   : write request and record; ignored when full unless popping
//   pop         : read request; ignored when empty
//   full, empty : occupancy flags
//   head        : oldest record, held stable until popped
module q3_result_fifo
  import q3_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       push,
  input  tally_rec_t din,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output tally_rec_t head
);

  tally_rec_t mem_q [FIFO_DEPTH];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] cnt_q;
  logic       do_push;
  logic       do_pop;

  assign empty   = (cnt_q == 2'd0);
  assign full    = (cnt_q == 2'(FIFO_DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop on the same edge frees the slot, so a push into a full buffer still lands.
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/q3_window_tally.sv
// Tallies qualifying detector windows per frame, queues one record per frame,
// and flags runs of consecutive qualifying windows.
//   clk, resetn        : clock, asynchronous active-low reset
//   en                 : 1 = collect, 0 = abandon partial frame and idle
//   win_valid, win_hit : window strobe and its qualify flag
//   res_ready          : consumer accepts head record
//   res_valid, res_hits, res_frame_id : head record of the result buffer
//   run_alarm          : run of hit windows reached RUN_THRESH
//   drop               : one-cycle pulse, completed frame lost to a full buffer
//   busy               : collecting
//
// state   | meaning
// IDLE    | not counting; windows ignored
// COLLECT | counting windows into the current frame
module q3_window_tally
  import q3_pkg::*;
#(
  parameter int FRAME_WINDOWS = 8,
  parameter int RUN_THRESH    = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             win_valid,
  input  logic             win_hit,
  input  logic             res_ready,
  output logic             res_valid,
  output logic [CNT_W-1:0] res_hits,
  output logic [7:0]       res_frame_id,
  output logic             run_alarm,
  output logic             drop,
  output logic             busy
);

  localparam int RUN_W = $clog2(RUN_THRESH + 1);

  tally_state_t     state_q, state_d;
  logic [7:0]       win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic [7:0]       frame_id_q, frame_id_d;
  logic             run_alarm_q, run_alarm_d;
  logic             drop_q, drop_d;

  logic             push;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] hit_inc;
  tally_rec_t       push_rec;
  tally_rec_t       head;

  assign hit_inc  = hit_cnt_q + CNT_W'(win_hit);
  assign push_rec = '{frame_id: frame_id_q, hits: hit_inc};

  always_comb begin
    state_d     = state_q;
    win_cnt_d   = win_cnt_q;
    hit_cnt_d   = hit_cnt_q;
    run_cnt_d   = run_cnt_q;
    frame_id_d  = frame_id_q;
    run_alarm_d = 1'b0;
    drop_d      = 1'b0;
    push        = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) state_d = COLLECT;
      end
      COLLECT: begin
        if (!en) begin
          state_d   = IDLE;
          win_cnt_d = '0;
          hit_cnt_d = '0;
          run_cnt_d = '0;
        end else begin
          if (win_valid) begin
            if (!win_hit)                                 run_cnt_d = '0;
            else if (run_cnt_q != RUN_W'(RUN_THRESH))     run_cnt_d = run_cnt_q + 1'b1;
            if (win_cnt_q == 8'(FRAME_WINDOWS - 1)) begin
              push       = 1'b1;
              win_cnt_d  = '0;
              hit_cnt_d  = '0;
              frame_id_d = frame_id_q + 8'd1;
              // When full the head is valid, so res_ready alone decides whether a slot frees up.
              drop_d     = fifo_full & ~res_ready;
            end else begin
              win_cnt_d  = win_cnt_q + 8'd1;
              hit_cnt_d  = hit_inc;
            end
          end
          run_alarm_d = (run_cnt_d >= RUN_W'(RUN_THRESH));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      win_cnt_q   <= '0;
      hit_cnt_q   <= '0;
      run_cnt_q   <= '0;
      frame_id_q  <= '0;
      run_alarm_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_cnt_q   <= win_cnt_d;
      hit_cnt_q   <= hit_cnt_d;
      run_cnt_q   <= run_cnt_d;
      frame_id_q  <= frame_id_d;
      run_alarm_q <= run_alarm_d;
      drop_q      <= drop_d;
    end
  end

  q3_result_fifo u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .din    (push_rec),
    .pop    (res_ready),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (head)
  );

  assign res_valid    = ~fifo_empty;
  assign res_hits     = head.hits;
  assign res_frame_id = head.frame_id;
  assign run_alarm    = run_alarm_q;
  assign drop         = drop_q;
  assign busy         = (state_q == COLLECT);

endmodule

// File: tb/tb_q3_window_tally.sv
module tb_q3_window_tally;
  localparam int FW = 8;
  localparam int RT = 3;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       en = 1'b0;
  logic       win_valid = 1'b0;
  logic       win_hit = 1'b0;
  logic       res_ready = 1'b0;
  logic       res_valid;
  logic [3:0] res_hits;
  logic [7:0] res_frame_id;
  logic       run_alarm;
  logic       drop;
  logic       busy;

  always #5 clk = ~clk;

  q3_window_tally #(.FRAME_WINDOWS(FW), .RUN_THRESH(RT)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .en           (en),
    .win_valid    (win_valid),
    .win_hit      (win_hit),
    .res_ready    (res_ready),
    .res_valid    (res_valid),
    .res_hits     (res_hits),
    .res_frame_id (res_frame_id),
    .run_alarm    (run_alarm),
    .drop         (drop),
    .busy         (busy)
  );

  typedef struct {int id; int hits;} rec_t;
  rec_t sb[$];

  int errors = 0;
  int checks = 0;

  // Reference model state: plain counts, recomputed from the frame rules.
  bit m_coll;
  int m_wc, m_hc, m_run, m_fid, m_occ, m_frames;
  bit m_alarm, m_drop;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    sb.delete();
    m_coll = 0; m_wc = 0; m_hc = 0; m_run = 0; m_fid = 0; m_occ = 0;
    m_alarm = 0; m_drop = 0;
  endtask

  // One clock: advance the model with the inputs the DUT sampled, then check.
  task automatic cyc();
    bit pop;
    @(posedge clk);
    pop = res_ready && (m_occ > 0);
    m_drop = 0;
    if (!m_coll) begin
      if (en) m_coll = 1;
    end else if (!en) begin
      m_coll = 0; m_wc = 0; m_hc = 0; m_run = 0;
    end else if (win_valid) begin
      m_wc++;
      m_hc += int'(win_hit);
      m_run = win_hit ? ((m_run < RT) ? m_run + 1 : RT) : 0;
      if (m_wc == FW) begin
        if (m_occ == 2 && !pop) m_drop = 1;
        else begin
          sb.push_back('{m_fid, m_hc});
          m_occ++;
        end
        m_fid = (m_fid + 1) % 256;
        m_wc = 0; m_hc = 0;
        m_frames++;
      end
    end
    m_alarm = m_coll && (m_run >= RT);
    if (pop) m_occ--;
    #1;
    chk("res_valid", int'(res_valid), int'(m_occ > 0));
    chk("run_alarm", int'(run_alarm), int'(m_alarm));
    chk("drop", int'(drop), int'(m_drop));
    chk("busy", int'(busy), int'(m_coll));
  endtask

  task automatic drv(input bit e, input bit v, input bit h, input bit r);
    en = e; win_valid = v; win_hit = h; res_ready = r;
    cyc();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #2;
    chk("rst_valid", int'(res_valid), 0);
    chk("rst_hits", int'(res_hits), 0);
    chk("rst_id", int'(res_frame_id), 0);
    chk("rst_alarm", int'(run_alarm), 0);
    chk("rst_drop", int'(drop), 0);
    chk("rst_busy", int'(busy), 0);
    model_clear();
    en = 0; win_valid = 0; win_hit = 0; res_ready = 0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic frame(input bit [7:0] pat, input bit r);
    for (int i = 0; i < FW; i++) drv(1, 1, pat[7-i], r);
  endtask

  // Monitor: pops the scoreboard whenever the DUT hands over a record.
  bit         prev_stall = 0;
  logic [11:0] prev_head;
  always @(negedge clk) begin
    if (!resetn) prev_stall = 0;
    else begin
      if (prev_stall) begin
        checks++;
        if (!res_valid || {res_hits, res_frame_id} !== prev_head) begin
          errors++;
          $display("FAIL stall_stable: got v=%0b %0d/%0d expected held %0d/%0d",
                   res_valid, res_hits, res_frame_id, prev_head[11:8], prev_head[7:0]);
        end
      end
      if (res_valid && res_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rec_unexpected: got id=%0d hits=%0d expected none", res_frame_id, res_hits);
        end else begin
          rec_t e;
          e = sb.pop_front();
          if (int'(res_frame_id) != e.id || int'(res_hits) != e.hits) begin
            errors++;
            $display("FAIL rec: got id=%0d hits=%0d expected id=%0d hits=%0d",
                     res_frame_id, res_hits, e.id, e.hits);
          end
        end
      end
      prev_stall = res_valid && !res_ready;
      prev_head  = {res_hits, res_frame_id};
    end
  end

  initial begin
    int ncyc;
    model_clear();
    m_frames = 0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // 1: reset mid-run, then a known frame
    drv(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drv(1, 1, 1, 0);
    do_reset();
    drv(1, 1, 1, 0);                 // en-rise edge: window ignored
    frame(8'b1101_0011, 0);
    chk("t1_hits", int'(res_hits), 5);
    chk("t1_id", int'(res_frame_id), 0);

    // 2: three frames with no consumer -> third dropped; then drain; next frame id 3
    do_reset();
    drv(1, 0, 0, 0);
    frame(8'b1111_0000, 0);
    frame(8'b0000_0001, 0);
    frame(8'b1010_1010, 0);
    chk("t2_drop", int'(drop), 1);
    for (int i = 0; i < 3; i++) drv(1, 0, 0, 1);
    frame(8'b0110_0110, 1);
    drv(1, 0, 0, 1);

    // 3: full buffer, final strobe coincides with a pop -> no drop
    do_reset();
    drv(1, 0, 0, 0);
    frame(8'b1000_0000, 0);
    frame(8'b1100_0000, 0);
    for (int i = 0; i < FW - 1; i++) drv(1, 1, 1, 0);
    drv(1, 1, 1, 1);
    chk("t3_nodrop", int'(drop), 0);
    for (int i = 0; i < 4; i++) drv(1, 0, 0, 1);

    // 4: run alarm, then a run straddling a frame boundary
    do_reset();
    drv(1, 0, 0, 1);
    drv(1, 1, 1, 1); drv(1, 1, 1, 1); drv(1, 1, 1, 1);
    chk("t4_alarm_up", int'(run_alarm), 1);
    drv(1, 1, 0, 1);
    chk("t4_alarm_dn", int'(run_alarm), 0);
    for (int i = 0; i < 4; i++) drv(1, 1, 0, 1);  // finish frame 0 (windows 4..7)
    for (int i = 0; i < 7; i++) drv(1, 1, 0, 1);
    drv(1, 1, 1, 1); drv(1, 1, 1, 1); drv(1, 1, 1, 1);
    chk("t4_straddle", int'(run_alarm), 1);
    drv(0, 0, 0, 1);
    chk("t4_en_clr", int'(run_alarm), 0);

    // 5: abandon a partial frame; windows in IDLE and on en-rise ignored
    do_reset();
    drv(1, 0, 0, 1);
    for (int i = 0; i < 5; i++) drv(1, 1, 1, 1);
    drv(0, 1, 1, 1); drv(0, 1, 1, 1);
    drv(1, 1, 1, 1);
    frame(8'b0100_0001, 1);
    chk("t5_hits", int'(res_hits), 2);
    chk("t5_id", int'(res_frame_id), 0);
    drv(1, 0, 0, 1);

    // 6: random traffic past a frame_id wrap
    do_reset();
    m_frames = 0;
    ncyc = 0;
    while (m_frames < 270 && ncyc < 40000) begin
      drv(($urandom_range(99) < 98), ($urandom_range(99) < 75),
          $urandom_range(1), ($urandom_range(99) < 70));
      ncyc++;
    end
    chk("t6_frames_done", int'(m_frames >= 270), 1);
    for (int i = 0; i < 6; i++) drv(0, 0, 0, 1);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
